// File: rtl/regfile_bel_param.sv
// regfile_bel_param: parametrised register-file BEL for the RegFile tile.
// One write port, NUM_RD independent read ports. Each read port can be
// combinational or registered (ConfigBits[k]); ConfigBits[NUM_RD] enables
// write-to-read bypass. The whole array clears asynchronously on RESETn.
// Optional feature macro: REGFILE_PARITY_EN adds a per-entry even-parity bit
// and a sticky ERR flag; without it ERR is tied to 0.
module regfile_bel_param #(
  parameter int DATA_W       = 4,
  parameter int ADDR_W       = 5,
  parameter int NUM_RD       = 2,
  parameter int NoConfigBits = NUM_RD + 1
) (
  input  logic                       UserCLK,
  input  logic                       RESETn,
  input  logic [ADDR_W-1:0]          W_ADR,
  input  logic [DATA_W-1:0]          W_DATA,
  input  logic                       W_en,
  input  logic [NUM_RD*ADDR_W-1:0]   R_ADR,
  output logic [NUM_RD*DATA_W-1:0]   R_DATA,
  input  logic [NoConfigBits-1:0]    ConfigBits,
  output logic                       ERR
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              bypass_en;

  assign bypass_en = ConfigBits[NUM_RD];

  // Storage array: async clear dominates any write in flight.
  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (W_en) begin
      mem[W_ADR] <= W_DATA;
    end
  end

`ifdef REGFILE_PARITY_EN
  logic              par_mem [DEPTH];
  logic [NUM_RD-1:0] par_bad;

  // Parity array: even parity of the written word; cleared entries (0/0) are valid.
  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < DEPTH; i++) par_mem[i] <= 1'b0;
    end else if (W_en) begin
      par_mem[W_ADR] <= ^W_DATA;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      ERR <= 1'b0;
    end else if (|par_bad) begin
      ERR <= 1'b1;
    end
  end
`else
  assign ERR = 1'b0;
`endif

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              bypass_hit;
    logic [DATA_W-1:0] comb_data;
    logic [DATA_W-1:0] reg_data;

    assign addr       = R_ADR[k*ADDR_W +: ADDR_W];
    assign bypass_hit = bypass_en && W_en && (addr == W_ADR);
    assign comb_data  = bypass_hit ? W_DATA : mem[addr];

    // Output register tracks the combinational value every cycle, whatever
    // the mode, so switching to registered shows the last captured word.
    always_ff @(posedge UserCLK or negedge RESETn) begin
      if (!RESETn) begin
        reg_data <= '0;
      end else begin
        reg_data <= comb_data;
      end
    end

    assign R_DATA[k*DATA_W +: DATA_W] = ConfigBits[k] ? reg_data : comb_data;

`ifdef REGFILE_PARITY_EN
    // Bypassed data never came from the array, so it is never checked.
    assign par_bad[k] = !bypass_hit && ((^mem[addr]) != par_mem[addr]);
`endif
  end

endmodule

// File: tb/tb_regfile_bel_param.sv
// Testbench for regfile_bel_param (ADDR_W=6, DATA_W=8, NUM_RD=3).
// Directed scenarios plus randomized traffic checked against an array model.
module tb_regfile_bel_param;

  localparam int AW  = 6;
  localparam int DW  = 8;
  localparam int NR  = 3;
  localparam int NCB = NR + 1;
  localparam int DEPTH = 2 ** AW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [AW-1:0]     w_adr;
  logic [DW-1:0]     w_data;
  logic              w_en;
  logic [NR*AW-1:0]  r_adr;
  logic [NR*DW-1:0]  r_data;
  logic [NCB-1:0]    cfg;
  logic              err;

  regfile_bel_param #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .UserCLK    (clk),
    .RESETn     (rst_n),
    .W_ADR      (w_adr),
    .W_DATA     (w_data),
    .W_en       (w_en),
    .R_ADR      (r_adr),
    .R_DATA     (r_data),
    .ConfigBits (cfg),
    .ERR        (err)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_reg [NR];
  logic          m_bad [DEPTH];
  logic          m_err;
  logic [DW-1:0] obs   [NR];

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] port_adr(input int k);
    return r_adr[k*AW +: AW];
  endfunction

  function automatic logic hit(input int k);
    return cfg[NR] && w_en && (port_adr(k) == w_adr);
  endfunction

  function automatic logic [DW-1:0] exp_comb(input int k);
    if (hit(k)) return w_data;
    return m_mem[port_adr(k)];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_bad[i] = 1'b0;
    end
    for (int k = 0; k < NR; k++) m_reg[k] = '0;
    m_err = 1'b0;
  endtask

  // Entered just after a rising edge with inputs already driven; checks the
  // outputs mid-cycle, then advances the model across the next rising edge.
  task automatic step();
    logic [DW-1:0] nxt [NR];
    @(negedge clk);
    for (int k = 0; k < NR; k++) begin
      obs[k] = r_data[k*DW +: DW];
      chk($sformatf("rdata%0d", k), obs[k], cfg[k] ? m_reg[k] : exp_comb(k));
    end
    chk("err", err, m_err);
    @(posedge clk);
    for (int k = 0; k < NR; k++) begin
      nxt[k] = exp_comb(k);
      if (!hit(k) && m_bad[port_adr(k)]) m_err = 1'b1;
    end
    for (int k = 0; k < NR; k++) m_reg[k] = nxt[k];
    if (w_en) begin
      m_mem[w_adr] = w_data;
      m_bad[w_adr] = 1'b0;
    end
    #1;
  endtask

  task automatic set_rd(input int k, input int a);
    r_adr[k*AW +: AW] = AW'(a);
  endtask

  task automatic wr(input int a, input int d);
    w_en = 1'b1; w_adr = AW'(a); w_data = DW'(d);
  endtask

  initial begin
    rst_n = 1'b0; w_en = 1'b0; w_adr = '0; w_data = '0; r_adr = '0; cfg = '0;
    model_reset();
    #3;
    chk("rst_rdata", r_data, '0);
    chk("rst_err", err, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // reset asserted mid-write discards the write
    wr(3, 'hA); set_rd(0, 3); cfg = 4'b0010;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rdata", r_data, '0);
    chk("midrst_err", err, 1'b0);
    model_reset();
    @(posedge clk); #1;
    w_en = 1'b0; cfg = '0;
    rst_n = 1'b1;
    step();
    chk("rst_addr3", obs[0], 'h0);

    // combinational read, two ports on the same address
    wr(7, 'h5); step();
    wr(2, 'hC); step();
    w_en = 1'b0; set_rd(0, 7); set_rd(1, 7); set_rd(2, 2);
    step();
    chk("comb_p0", obs[0], 'h5);
    chk("comb_p1", obs[1], 'h5);
    chk("comb_p2", obs[2], 'hC);

    // registered read: old value until the edge
    cfg = 4'b0001; step();
    set_rd(0, 2); step();
    chk("reg_hold", obs[0], 'h5);
    step();
    chk("reg_next", obs[0], 'hC);

    // bypass off: pre-write value this cycle, new value next
    cfg = 4'b0000; wr(4, 'h9); set_rd(1, 4); step();
    chk("nobyp_old", obs[1], 'h0);
    w_en = 1'b0; step();
    chk("nobyp_new", obs[1], 'h9);

    // bypass on: write-through same cycle
    cfg = 4'b1000; wr(5, 'h9); set_rd(1, 5); step();
    chk("byp_thru", obs[1], 'h9);
    w_en = 1'b0; cfg = '0;

    // depth sweep
    for (int a = 0; a < DEPTH; a++) begin
      wr(a, a ^ 'hA5); step();
    end
    w_en = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(0, a); set_rd(1, (a + 21) % DEPTH); set_rd(2, (a + 42) % DEPTH);
      step();
      chk("sweep_p0", obs[0], DW'(a ^ 'hA5));
      chk("sweep_p1", obs[1], DW'(((a + 21) % DEPTH) ^ 'hA5));
      chk("sweep_p2", obs[2], DW'(((a + 42) % DEPTH) ^ 'hA5));
    end

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 15) == 0) cfg = NCB'($urandom);
      w_en   = 1'($urandom);
      w_data = DW'($urandom);
      for (int k = 0; k < NR; k++) set_rd(k, int'($urandom_range(0, DEPTH - 1)));
      if ($urandom_range(0, 2) == 0)
        w_adr = port_adr(int'($urandom_range(0, NR - 1)));
      else
        w_adr = AW'($urandom);
      step();
    end

`ifdef REGFILE_PARITY_EN
    // flip a stored parity bit and read it back
    w_en = 1'b0; cfg = '0;
    for (int k = 0; k < NR; k++) set_rd(k, 10);
    step();
    dut.par_mem[1] = ~dut.par_mem[1];
    m_bad[1] = 1'b1;
    set_rd(0, 1);
    step();
    chk("par_before", err, 1'b0);
    set_rd(0, 10);
    step();
    chk("par_set", err, 1'b1);
    for (int n = 0; n < 4; n++) step();
    chk("par_sticky", err, 1'b1);
    rst_n = 1'b0; #1;
    chk("par_clr", err, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/regfile_bel_param.md
Name: regfile_bel_param

Overview:
- Parametrised register-file BEL for the fabric's RegFile tile; the successor to the fixed 32x4, two-read/one-write tile primitive.
- Depth, data width and read-port count are generalised.
- Adds per-port configurable output registering, write-to-read bypass and an async-clearable array.
- Driven by the tile switch matrix; mode bits come from the tile's configuration latches via ConfigBits.

Parameters:
- DATA_W, 4, bits per entry.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of independent read ports (1..4).
- NoConfigBits, NUM_RD+1, configuration bits consumed.

Ports:
- UserCLK  input  1  fabric user clock; all state updates on rising edge.
- RESETn  input  1  asynchronous active-low reset.
- W_ADR  input  ADDR_W  write address.
- W_DATA  input  DATA_W  write data.
- W_en  input  1  write enable.
- R_ADR  input  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W].
- R_DATA  output  NUM_RD*DATA_W  packed read data; port k at bits [k*DATA_W +: DATA_W].
- ConfigBits  input  NoConfigBits  bits [NUM_RD-1:0] = per-port registered mode (1 = registered); bit [NUM_RD] = bypass enable.
- ERR  output  1  parity error flag; present only with the optional feature, tied 0 otherwise.

Behaviour:
- Reset
  - RESETn low asynchronously clears every array entry to 0, every output register to 0, and ERR to 0.
  - Deassertion is sampled on the next UserCLK edge.
  - Reset asserted mid-write: the write is discarded and the entry reads 0.
- Write
  - On a rising edge with W_en=1, mem[W_ADR] <= W_DATA.
  - One write per cycle; last-value semantics.
- Read, combinational mode (cfg bit k = 0)
  - R_DATA[k] = mem[R_ADR[k]], same cycle.
  - Bypass bit = 1 and W_en=1 and R_ADR[k]==W_ADR: R_DATA[k] = W_DATA (write-through).
  - Bypass bit = 0: the old contents are returned until the edge.
- Read, registered mode (cfg bit k = 1)
  - An output register captures at each rising edge the value combinational mode would present that cycle, including the bypass decision.
  - Latency is one cycle.
  - Register holds its value between edges.
- Collisions
  - Multiple read ports at the same address are independent and all return identical data.
  - A read of an address being written without bypass returns the pre-write value in both modes.
- Configuration
  - ConfigBits are treated as static.
  - A change takes effect combinationally on the mux select.
  - The registered path keeps running regardless, so switching to registered shows the last captured value.
- Address width: no out-of-range case exists (full 2**ADDR_W depth); wrap-around is inherent.

Optional Feature:
- Macro REGFILE_PARITY_EN.
- When defined:
  - Each entry stores an extra even-parity bit computed from W_DATA on write.
  - On each read port the parity is recomputed; any mismatch sets the sticky ERR register on the next edge.
  - ERR is cleared only by RESETn.
  - Reset-cleared entries (all 0, parity 0) are valid.
  - Bypassed data is never flagged.
- When undefined: no parity storage; ERR is constant 0.

Test Plan:
- Reset: write 0xA to addr 3, assert RESETn low mid-cycle -> all R_DATA = 0 immediately; addr 3 reads 0 after release.
- Combinational read: write 0x5 to addr 7, next cycle set R_ADR0=7 with cfg=0 -> R_DATA0=0x5 same cycle; port1 at addr 7 also reads 0x5.
- Registered read: cfg bit0=1, R_ADR0 changes 7->2 (addr 2 holds 0xC) -> R_DATA0 shows 0x5 until the next edge, then 0xC.
- Bypass on: W_en=1, W_ADR=4, W_DATA=0x9, R_ADR1=4, bypass=1 -> R_DATA1=0x9 in the same cycle.
- Bypass off: same stimulus with bypass=0 -> old value 0x0 in that cycle, 0x9 the following cycle.
- Parity (REGFILE_PARITY_EN): force a stored bit flip at addr 1 via hierarchical deposit, then read addr 1 -> ERR=1 one edge later and stays 1 until RESETn.
- Depth sweep: ADDR_W=6, DATA_W=8, NUM_RD=3 -> write 0..63 with data=addr^0xA5, read all three ports -> every word matches.
